// File: rtl/DDR3SDRAMLocal.sv
// Shared DDR3 local-interface command constants used by controller-side blocks.
package DDR3SDRAMLocal;

    localparam int unsigned DDRCWidth = 3;

    localparam logic [DDRCWidth-1:0] DDR3CMD_Write = 3'b000;
    localparam logic [DDRCWidth-1:0] DDR3CMD_Read  = 3'b001;

endpackage

// File: rtl/dram_bram_responder_pkg.sv
// Types and constants for the BRAM-backed DRAM responder.
package dram_bram_responder_pkg;

    // Eight DRAM addresses map onto one data beat.
    localparam int unsigned BurstShift = 3;
    localparam int unsigned OutDepth   = 2;

    typedef enum logic [1:0] {
        EXEC_NONE,
        EXEC_WRITE,
        EXEC_READ,
        EXEC_BAD
    } exec_e;

endpackage

// File: rtl/FIFORAM.sv
// Show-ahead FIFO over a small array; the head entry is visible whenever o_valid is high.
module FIFORAM #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [Width-1:0] i_data,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [Width-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    assign i_ready = (count_q != CntW'(Depth));
    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];

    always_comb begin
        push     = i_valid && i_ready;
        pop      = o_valid && o_ready;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; occupancy alone defines validity.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/dram_bram_store.sv
// Single-port backing store: byte-enable write, registered read, contents survive reset.
module dram_bram_store #(
    parameter int unsigned DWidth   = 512,
    parameter int unsigned MWidth   = DWidth / 8,
    parameter int unsigned LogDepth = 12
) (
    input  logic                Clock,
    input  logic                we,
    input  logic [MWidth-1:0]   be,
    input  logic                re,
    input  logic [LogDepth-1:0] addr,
    input  logic [DWidth-1:0]   wdata,
    output logic [DWidth-1:0]   rdata
);
    localparam int unsigned Words = 2 ** LogDepth;

    logic [DWidth-1:0] mem_q [Words];
    logic [DWidth-1:0] rdata_q;

    always_ff @(posedge Clock) begin
        if (we) begin
            for (int b = 0; b < int'(MWidth); b++) begin
                if (be[b]) begin
                    mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dram_bram_responder.sv
// DRAM-interface responder backed by block RAM: queued commands and write beats,
// in-order execution, two-deep read return buffer.
module dram_bram_responder
    import DDR3SDRAMLocal::*;
    import dram_bram_responder_pkg::*;
#(
    parameter int unsigned AWidth    = 28,
    parameter int unsigned DWidth    = 512,
    parameter int unsigned MWidth    = DWidth / 8,
    parameter int unsigned LogDepth  = 12,
    parameter int unsigned CmdQDepth = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [AWidth-1:0]    CommandAddress,
    input  logic [DDRCWidth-1:0] Command,
    input  logic                 CommandValid,
    output logic                 CommandReady,
    input  logic [DWidth-1:0]    DataIn,
    input  logic [MWidth-1:0]    DataInMask,
    input  logic                 DataInValid,
    output logic                 DataInReady,
    output logic [DWidth-1:0]    DataOut,
    output logic                 DataOutValid,
    input  logic                 DataOutReady,
    output logic                 BadCmd
);
    localparam int unsigned CmdW = DDRCWidth + LogDepth;
    localparam int unsigned WrW  = MWidth + DWidth;

    logic                 run_q, run_d;
    logic                 bad_q, bad_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [1:0]           used_q, used_d;
    logic                 run_c;
    exec_e                exec;
    logic                 deliver;

    logic [CmdW-1:0]      cq_in, cq_data;
    logic                 cq_not_full, cq_valid;
    logic [DDRCWidth-1:0] head_cmd;
    logic [LogDepth-1:0]  head_idx;

    logic [WrW-1:0]       wq_data;
    logic                 wq_not_full, wq_valid;

    logic [DWidth-1:0]    of_data, rd_data;
    logic                 of_valid, of_push;
    logic                 oq_ready_unused;
    logic                 unused_addr;

    // Interfaces stay closed through reset and the first cycle after release.
    assign run_c        = Reset && run_q;
    assign CommandReady = run_c && cq_not_full;
    assign DataInReady  = run_c && wq_not_full;
    assign BadCmd       = bad_q;

    assign cq_in       = {Command, CommandAddress[LogDepth+BurstShift-1:BurstShift]};
    assign unused_addr = ^{CommandAddress[AWidth-1:LogDepth+BurstShift],
                           CommandAddress[BurstShift-1:0]};
    assign head_cmd    = cq_data[CmdW-1:LogDepth];
    assign head_idx    = cq_data[LogDepth-1:0];

    // An empty return buffer lets fresh RAM data go straight out.
    assign DataOut      = of_valid ? of_data : rd_data;
    assign DataOutValid = run_c && (of_valid || rd_pend_q);
    assign deliver      = DataOutValid && DataOutReady;
    assign of_push      = rd_pend_q && !(!of_valid && deliver);

    always_comb begin
        exec = EXEC_NONE;
        if (run_c && cq_valid) begin
            if (head_cmd == DDR3CMD_Write) begin
                if (wq_valid) exec = EXEC_WRITE;
            end else if (head_cmd == DDR3CMD_Read) begin
                if ((used_q < 2'd2) || deliver) exec = EXEC_READ;
            end else begin
                exec = EXEC_BAD;
            end
        end
        run_d     = 1'b1;
        bad_d     = bad_q || (exec == EXEC_BAD);
        rd_pend_d = (exec == EXEC_READ);
        used_d    = used_q + 2'(exec == EXEC_READ) - 2'(deliver);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            run_q     <= 1'b0;
            bad_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            used_q    <= '0;
        end else begin
            run_q     <= run_d;
            bad_q     <= bad_d;
            rd_pend_q <= rd_pend_d;
            used_q    <= used_d;
        end
    end

    FIFORAM #(.Width(CmdW), .Depth(CmdQDepth)) u_cmd_q (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_data  (cq_in),
        .i_valid (CommandValid && run_c),
        .i_ready (cq_not_full),
        .o_data  (cq_data),
        .o_valid (cq_valid),
        .o_ready (exec != EXEC_NONE)
    );

    FIFORAM #(.Width(WrW), .Depth(CmdQDepth)) u_wr_q (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_data  ({DataInMask, DataIn}),
        .i_valid (DataInValid && run_c),
        .i_ready (wq_not_full),
        .o_data  (wq_data),
        .o_valid (wq_valid),
        .o_ready (exec == EXEC_WRITE)
    );

    // Read credits guarantee this buffer never sees a push while full.
    FIFORAM #(.Width(DWidth), .Depth(OutDepth)) u_out_q (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_data  (rd_data),
        .i_valid (of_push),
        .i_ready (oq_ready_unused),
        .o_data  (of_data),
        .o_valid (of_valid),
        .o_ready (DataOutReady && run_c)
    );

    dram_bram_store #(.DWidth(DWidth), .MWidth(MWidth), .LogDepth(LogDepth)) u_store (
        .Clock (Clock),
        .we    (exec == EXEC_WRITE),
        .be    (~wq_data[WrW-1:DWidth]),
        .re    (exec == EXEC_READ),
        .addr  (head_idx),
        .wdata (wq_data[DWidth-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_dram_bram_responder.sv
// Directed and random checks of dram_bram_responder against an in-order command/data queue model.
module tb_dram_bram_responder;
    import DDR3SDRAMLocal::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = 8;
    localparam int unsigned LD = 4;
    localparam int unsigned QD = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [AW-1:0] CommandAddress;
    logic [2:0]    Command;
    logic          CommandValid, CommandReady;
    logic [DW-1:0] DataIn;
    logic [MW-1:0] DataInMask;
    logic          DataInValid, DataInReady;
    logic [DW-1:0] DataOut;
    logic          DataOutValid, DataOutReady;
    logic          BadCmd;

    dram_bram_responder #(
        .AWidth(AW), .DWidth(DW), .MWidth(MW), .LogDepth(LD), .CmdQDepth(QD)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .CommandAddress(CommandAddress), .Command(Command),
        .CommandValid(CommandValid), .CommandReady(CommandReady),
        .DataIn(DataIn), .DataInMask(DataInMask),
        .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
        .BadCmd(BadCmd)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [LD-1:0] idx;
    } mcmd_t;

    logic [DW-1:0]    mdl_mem [16];
    mcmd_t            cq[$];
    logic [MW+DW-1:0] dq[$];

    int            total = 0;
    int            bad = 0;
    int            nread = 0;
    int            nrd_acc = 0;
    logic          last_cacc = 1'b0;
    logic          last_dacc = 1'b0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_out = '0;
    logic [DW-1:0] last_rd = '0;

    // Retire queued commands in order until a read is at the head or a write lacks data.
    task automatic model_flush();
        mcmd_t            c;
        logic [MW+DW-1:0] d;
        while (cq.size() > 0) begin
            if (cq[0].cmd == DDR3CMD_Write) begin
                if (dq.size() == 0) break;
                c = cq.pop_front();
                d = dq.pop_front();
                for (int b = 0; b < int'(MW); b++)
                    if (!d[DW+b]) mdl_mem[c.idx][b*8 +: 8] = d[b*8 +: 8];
            end else if (cq[0].cmd == DDR3CMD_Read) begin
                break;
            end else begin
                c = cq.pop_front();
            end
        end
    endtask

    task automatic model_next_read(output logic ok, output logic [DW-1:0] v);
        mcmd_t c;
        ok = 1'b0;
        v  = '0;
        model_flush();
        if (cq.size() > 0 && cq[0].cmd == DDR3CMD_Read) begin
            c  = cq.pop_front();
            v  = mdl_mem[c.idx];
            ok = 1'b1;
        end
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic          ok;
        logic [DW-1:0] e;
        @(negedge Clock);
        last_cacc = Reset && CommandValid && CommandReady;
        last_dacc = Reset && DataInValid && DataInReady;
        if (hold_prev && Reset) begin
            total++;
            assert (DataOutValid === 1'b1 && DataOut === prev_out) else begin
                bad++;
                $error("FAIL hold_stable got=%h/%b exp=%h/1", DataOut, DataOutValid, prev_out);
            end
        end
        hold_prev = Reset && DataOutValid && !DataOutReady;
        prev_out  = DataOut;
        if (Reset && DataOutValid && DataOutReady) begin
            model_next_read(ok, e);
            total++;
            assert (ok === 1'b1 && DataOut === e) else begin
                bad++;
                $error("FAIL read_data got=%h exp=%h model_has_read=%b", DataOut, e, ok);
            end
            last_rd = DataOut;
            nread++;
        end
        if (last_cacc) begin
            cq.push_back({Command, CommandAddress[LD+2:3]});
            if (Command == DDR3CMD_Read) nrd_acc++;
        end
        if (last_dacc) dq.push_back({DataInMask, DataIn});
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
        int n;
        n = 0;
        CommandValid = 1'b1;
        Command = c;
        CommandAddress = a;
        do begin
            tick();
            n++;
        end while (!last_cacc && n < 200);
        CommandValid = 1'b0;
        total++;
        assert (last_cacc === 1'b1) else begin
            bad++;
            $error("FAIL cmd_timeout got=%b exp=1 addr=%h", last_cacc, a);
        end
    endtask

    task automatic send_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
        int n;
        n = 0;
        DataInValid = 1'b1;
        DataIn = d;
        DataInMask = m;
        do begin
            tick();
            n++;
        end while (!last_dacc && n < 200);
        DataInValid = 1'b0;
        total++;
        assert (last_dacc === 1'b1) else begin
            bad++;
            $error("FAIL data_timeout got=%b exp=1", last_dacc);
        end
    endtask

    task automatic wait_reads(input int target);
        int n;
        n = 0;
        while (nread < target && n < 300) begin
            tick();
            n++;
        end
        total++;
        assert (nread >= target) else begin
            bad++;
            $error("FAIL read_timeout got=%0d exp=%0d", nread, target);
        end
    endtask

    initial begin
        int acc, base, wr_acc, beats, r, n;
        Reset = 1'b0;
        CommandValid = 1'b0; Command = '0; CommandAddress = '0;
        DataInValid = 1'b0; DataIn = '0; DataInMask = '0;
        DataOutReady = 1'b1;

        repeat (3) tick();
        chk("rst_cmd_ready", DW'(CommandReady), '0);
        chk("rst_din_ready", DW'(DataInReady), '0);
        chk("rst_dout_valid", DW'(DataOutValid), '0);
        chk("rst_badcmd", DW'(BadCmd), '0);
        Reset = 1'b1;
        chk("post_rst_cmd_ready", DW'(CommandReady), '0);
        chk("post_rst_din_ready", DW'(DataInReady), '0);
        tick();
        chk("run_cmd_ready", DW'(CommandReady), DW'(1));
        chk("run_din_ready", DW'(DataInReady), DW'(1));

        // Fill every word so later reads have defined data.
        for (int i = 0; i < 16; i++) begin
            send_data({$urandom, $urandom}, '0);
            send_cmd(DDR3CMD_Write, AW'(i * 8));
        end

        // Full-beat write then minimum-latency read.
        send_data({8{8'hA5}}, '0);
        send_cmd(DDR3CMD_Write, 12'h028);
        repeat (4) tick();
        CommandValid = 1'b1; Command = DDR3CMD_Read; CommandAddress = 12'h028;
        tick();
        CommandValid = 1'b0;
        chk("lat_accept", DW'(last_cacc), DW'(1));
        chk("lat_n1_valid", DW'(DataOutValid), '0);
        tick();
        chk("lat_n2_valid", DW'(DataOutValid), DW'(1));
        chk("lat_n2_data", DataOut, {8{8'hA5}});
        tick();
        chk("lat_once", DW'(DataOutValid), '0);

        // Masked write merges only byte 0.
        send_data({8{8'hFF}}, 8'hFE);
        send_cmd(DDR3CMD_Write, 12'h028);
        send_cmd(DDR3CMD_Read, 12'h028);
        wait_reads(nread + 1);
        chk("mask_merge", last_rd, 64'hA5A5_A5A5_A5A5_A5FF);

        // Writes without data fill the command queue.
        for (int i = 0; i < 4; i++) send_cmd(DDR3CMD_Write, AW'((8 + i) * 8));
        chk("cmdq_full", DW'(CommandReady), '0);
        send_data({$urandom, $urandom}, 8'($urandom));
        chk("cmdq_still_full", DW'(CommandReady), '0);
        tick();
        chk("cmdq_drained", DW'(CommandReady), DW'(1));
        for (int i = 1; i < 4; i++) send_data({$urandom, $urandom}, '0);
        base = nread;
        for (int i = 0; i < 4; i++) send_cmd(DDR3CMD_Read, AW'((8 + i) * 8));
        wait_reads(base + 4);

        // Back-pressure: two buffered reads plus a full queue, then release.
        DataOutReady = 1'b0;
        for (int i = 0; i < 6; i++) send_cmd(DDR3CMD_Read, AW'(i * 8));
        repeat (3) tick();
        chk("bp_cmd_ready", DW'(CommandReady), '0);
        chk("bp_out_valid", DW'(DataOutValid), DW'(1));
        base = nread;
        DataOutReady = 1'b1;
        wait_reads(base + 6);
        repeat (6) tick();
        chk("bp_six_beats", DW'(nread - base), DW'(6));

        // One read accepted per cycle with output ready.
        acc = 0;
        base = nread;
        CommandValid = 1'b1; Command = DDR3CMD_Read;
        for (int i = 0; i < 8; i++) begin
            CommandAddress = AW'(i * 8);
            tick();
            if (last_cacc) acc++;
        end
        CommandValid = 1'b0;
        chk("throughput", DW'(acc), DW'(8));
        wait_reads(base + 8);

        // Unknown command is a sticky no-op.
        send_cmd(3'b111, 12'h028);
        repeat (2) tick();
        chk("badcmd_set", DW'(BadCmd), DW'(1));
        send_cmd(DDR3CMD_Read, 12'h028);
        wait_reads(nread + 1);
        chk("badcmd_no_write", last_rd, 64'hA5A5_A5A5_A5A5_A5FF);

        // Random traffic with aliasing addresses and random back-pressure.
        wr_acc = 0;
        beats = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!CommandValid && $urandom_range(0, 2) != 0) begin
                r = int'($urandom_range(0, 9));
                CommandValid = 1'b1;
                Command = (r < 4) ? DDR3CMD_Write : (r < 9) ? DDR3CMD_Read : 3'b110;
                CommandAddress = AW'($urandom);
            end
            if (!DataInValid && beats < wr_acc + 2 && $urandom_range(0, 1) != 0) begin
                DataInValid = 1'b1;
                DataIn = {$urandom, $urandom};
                DataInMask = MW'($urandom);
            end
            DataOutReady = ($urandom_range(0, 3) != 0);
            tick();
            if (last_cacc) begin
                if (Command == DDR3CMD_Write) wr_acc++;
                CommandValid = 1'b0;
            end
            if (last_dacc) begin
                beats++;
                DataInValid = 1'b0;
            end
        end
        DataOutReady = 1'b1;
        n = 0;
        while ((CommandValid || beats < wr_acc) && n < 300) begin
            if (!DataInValid && beats < wr_acc) begin
                DataInValid = 1'b1;
                DataIn = {$urandom, $urandom};
                DataInMask = MW'($urandom);
            end
            tick();
            if (last_cacc) begin
                if (Command == DDR3CMD_Write) wr_acc++;
                CommandValid = 1'b0;
            end
            if (last_dacc) begin
                beats++;
                DataInValid = 1'b0;
            end
            n++;
        end
        DataInValid = 1'b0;
        repeat (20) tick();
        chk("rand_all_reads", DW'(nread), DW'(nrd_acc));
        model_flush();
        chk("rand_model_idle", DW'(cq.size()), '0);

        // Reset clears flags and buffers but keeps RAM contents.
        Reset = 1'b0;
        tick();
        chk("rst2_badcmd", DW'(BadCmd), '0);
        chk("rst2_out_valid", DW'(DataOutValid), '0);
        chk("rst2_cmd_ready", DW'(CommandReady), '0);
        cq.delete();
        dq.delete();
        hold_prev = 1'b0;
        Reset = 1'b1;
        repeat (2) tick();
        base = nread;
        for (int i = 0; i < 16; i++) send_cmd(DDR3CMD_Read, AW'(i * 8));
        wait_reads(base + 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
